seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
Runtime-programmable serial bit-pattern detector. It is the parametrised successor to the fixed 4-bit "1010" detector. The block adds pattern length up to MAX_LEN, a selectable overlap/non-overlap mode, a valid-qualified input, and a saturating match counter. It sits on a serial data path, with the config port driven by a control register block.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
LEN_W, 4, width of cfg_len; must hold MAX_LEN
CNT_W, 16, width of match_count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
cfg_load  in  1  one-cycle strobe; latches cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 is the last
cfg_len  in  LEN_W  pattern length in bits
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
in_valid  in  1  data_in is sampled only when high
data_in  in  1  serial data bit
count_clr  in  1  synchronous clear of match_count
armed  out  1  high once a valid config is loaded
detected  out  1  registered one-cycle match pulse
match_count  out  CNT_W  saturating count of matches

Behaviour:
- Reset (async) values:
  - state UNCFG; pattern 0, len 0, overlap 0.
  - history 0, fill 0.
  - detected 0, match_count 0, armed 0.
- State machine: UNCFG, ARMED.
  - UNCFG -> ARMED on cfg_load with effective length >= 1.
  - ARMED -> UNCFG on cfg_load with cfg_len = 0.
  - ARMED -> ARMED on any other cfg_load (reconfigure).
  - reset -> UNCFG from any state.
  - armed = (state == ARMED).
- Effective length:
  - cfg_len > MAX_LEN clamps to MAX_LEN.
  - cfg_len = 0 disables detection.
  - pattern bits at or above len are ignored.
- History register hist[MAX_LEN-1:0]:
  - When in_valid=1 in ARMED, hist <= {hist[MAX_LEN-2:0], data_in}.
  - fill counts valid bits since the last flush, saturating at MAX_LEN.
  - in_valid=0 holds hist and fill.
  - In UNCFG, input is ignored.
- Match:
  - Evaluated on the post-shift history and fill (hist_n, fill_n) in a cycle with in_valid=1 and ARMED.
  - Condition: fill_n >= len and hist_n[len-1:0] == pattern[len-1:0].
- Latency: detected = 1 in the cycle after the clock edge that sampled the completing bit; high for exactly one cycle per match.
- Overlap=1: fill is untouched on a match, so a suffix can start the next match.
- Overlap=0: on a match, fill <= 0, so no bit of the matched sequence is reused.
- cfg_load:
  - Highest priority. Latches the new config and flushes hist and fill to 0.
  - detected <= 0 on the next edge.
  - A data bit presented with in_valid in the same cycle is discarded.
  - match_count is unaffected.
- match_count:
  - Increments by 1 on each match and saturates at all-ones (no wrap).
  - count_clr alone -> 0.
  - count_clr in the same cycle as a match -> 1.
- Reset mid-stream discards partial history and config; the block must be reloaded.

Test Plan:
1. Overlap mode:
   - Stimulus: cfg pattern=4'b1010 (LSBs), len=4, overlap=1; stream 1,0,1,0,1,0,1,0 with continuous in_valid.
   - Response: detected pulses after bits 4, 6 and 8; match_count=3.
2. Non-overlap mode:
   - Stimulus: same stream with overlap=0.
   - Response: detected after bits 4 and 8 only; match_count=2.
3. Valid gaps and full-width pattern:
   - Stimulus: len=8, pattern=8'hA5 (1,0,1,0,0,1,0,1); 2 idle in_valid=0 cycles between every bit, then 8'hA5 again with no gaps.
   - Response: exactly one pulse per occurrence, each one cycle after the last valid bit; no pulse in idle cycles; match_count=2.
4. Counter saturation and clear (CNT_W=4):
   - Stimulus: 20 overlapping matches of pattern=1 with len=1.
   - Response: count saturates at 15. count_clr alone -> 0. count_clr coincident with a match -> 1.
5. Reset mid-stream:
   - Stimulus: after loading 1010, feed 1,0,1, assert reset for 1 cycle, then feed 0.
   - Response: no detect; armed=0; match_count=0; data ignored until the next cfg_load.
6. Reconfiguration and disable:
   - Stimulus (a): cfg_load mid-pattern with an in_valid bit in the same cycle.
   - Response (a): history flushed and that bit is not counted, so the next match needs len fresh bits.
   - Stimulus (b): cfg_load with cfg_len=0.
   - Response (b): armed=0 and no detects.
   - Stimulus (c): cfg_len=12 with MAX_LEN=8.
   - Response (c): behaves as len=8.

Source files
------------

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// valid-qualified input and a saturating match counter.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               data_in,
  input  logic               count_clr,
  output logic               armed,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count
);

  localparam int FILL_W = $clog2(MAX_LEN + 1);

  typedef enum logic {UNCFG, ARMED} state_t;

  state_t             state, state_nx;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic [MAX_LEN-1:0] hist, hist_n;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [LEN_W-1:0]   len_eff;
  logic               sample;
  logic               match;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (int'(l) > MAX_LEN) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  always_comb begin
    state_nx = state;
    len_eff  = clamp_len(cfg_len);
    if (cfg_load) state_nx = (len_eff != '0) ? ARMED : UNCFG;
    hist_n = {hist[MAX_LEN-2:0], data_in};
    fill_n = (int'(fill) >= MAX_LEN) ? fill : fill + FILL_W'(1);
    // A bit arriving alongside cfg_load is discarded along with the flushed history.
    sample = (state == ARMED) && in_valid && !cfg_load;
    match  = sample && (int'(fill_n) >= int'(len)) &&
             (((hist_n ^ pattern) & len_mask(len)) == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= UNCFG;
    else       state <= state_nx;
  end

  assign armed = (state == ARMED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern     <= '0;
      len         <= '0;
      overlap     <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      detected    <= 1'b0;
      match_count <= '0;
    end else begin
      if (cfg_load) begin
        pattern <= cfg_pattern;
        len     <= len_eff;
        overlap <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
      end else if (sample) begin
        hist <= hist_n;
        fill <= (match && !overlap) ? '0 : fill_n;
      end
      detected <= match;
      if (count_clr)  match_count <= match ? CNT_W'(1) : '0;
      else if (match) match_count <= sat_inc(match_count);
    end
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               data_in;
  logic               count_clr;
  logic               armed;
  logic               detected;
  logic [CNT_W-1:0]   match_count;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .data_in(data_in), .count_clr(count_clr), .armed(armed),
    .detected(detected), .match_count(match_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: the valid bits seen since the last flush, newest last.
  bit         q[$];
  bit         m_armed;
  int         m_len;
  bit [7:0]   m_pat;
  bit         m_ovl;
  bit         m_det;
  int         m_cnt;

  logic [7:0] cur_pat;
  logic [3:0] cur_len;
  logic       cur_ovl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_armed = 0; m_len = 0; m_pat = '0; m_ovl = 0; m_det = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit cl, input bit [7:0] pat, input int ln,
                            input bit ov, input bit v, input bit d, input bit clr);
    bit match;
    match = 0;
    if (cl) begin
      m_len   = (ln > MAX_LEN) ? MAX_LEN : ln;
      m_pat   = pat;
      m_ovl   = ov;
      m_armed = (m_len != 0);
      q.delete();
    end else if (m_armed && v) begin
      q.push_back(d);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      if (q.size() >= m_len) begin
        match = 1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size()-1-i] != m_pat[i]) match = 0;
      end
      if (match && !m_ovl) q.delete();
    end
    m_det = match;
    if (clr) m_cnt = match ? 1 : 0;
    else if (match && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".detected"}, 32'(detected), 32'(m_det));
    chk({tag, ".armed"}, 32'(armed), 32'(m_armed));
    chk({tag, ".count"}, 32'(match_count), 32'(m_cnt));
  endtask

  task automatic step(input string tag, input bit cl, input bit v, input bit d, input bit clr);
    cfg_load = cl; cfg_pattern = cur_pat; cfg_len = cur_len; cfg_overlap = cur_ovl;
    in_valid = v; data_in = d; count_clr = clr;
    @(posedge clk);
    model_edge(cl, cur_pat, int'(cur_len), cur_ovl, v, d, clr);
    #1;
    check_outputs(tag);
    if (detected === 1'b1) pulses++;
    cfg_load = 0; in_valid = 0; count_clr = 0;
  endtask

  task automatic load(input string tag, input logic [7:0] p, input logic [3:0] l, input logic o);
    cur_pat = p; cur_len = l; cur_ovl = o;
    step(tag, 1, 0, 0, 0);
  endtask

  task automatic feed(input string tag, input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, 0, 1, bits[i], 0);
  endtask

  initial begin
    logic [7:0] seq;
    reset = 1; cfg_load = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    in_valid = 0; data_in = 0; count_clr = 0;
    cur_pat = '0; cur_len = '0; cur_ovl = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset = 0;

    // Overlapping 1010 detection
    load("t1load", 8'h0A, 4'd4, 1);
    pulses = 0;
    feed("t1", 8'hAA, 8);
    chk("t1.pulses", 32'(pulses), 32'd3);
    chk("t1.count", 32'(match_count), 32'd3);

    // Non-overlapping
    step("t2clr", 0, 0, 0, 1);
    load("t2load", 8'h0A, 4'd4, 0);
    pulses = 0;
    feed("t2", 8'hAA, 8);
    chk("t2.pulses", 32'(pulses), 32'd2);
    chk("t2.count", 32'(match_count), 32'd2);

    // Full-width pattern with valid gaps, then back to back
    step("t3clr", 0, 0, 0, 1);
    load("t3load", 8'hA5, 4'd8, 1);
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      step("t3gap", 0, 1, cur_pat[i], 0);
      step("t3idle", 0, 0, 1, 0);
      step("t3idle", 0, 0, 0, 0);
    end
    feed("t3b2b", 8'hA5, 8);
    chk("t3.pulses", 32'(pulses), 32'd2);
    chk("t3.count", 32'(match_count), 32'd2);

    // Counter saturation and clear
    load("t4load", 8'h01, 4'd1, 1);
    step("t4clr", 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step("t4run", 0, 1, 1, 0);
    chk("t4.sat", 32'(match_count), 32'd15);
    step("t4clronly", 0, 0, 0, 1);
    chk("t4.clr", 32'(match_count), 32'd0);
    step("t4clrmatch", 0, 1, 1, 1);
    chk("t4.clrmatch", 32'(match_count), 32'd1);

    // Reset mid-stream
    load("t5load", 8'h0A, 4'd4, 1);
    feed("t5pre", 8'h05, 3);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    check_outputs("t5rst");
    feed("t5post", 8'h00, 1);
    feed("t5ign", 8'h0A, 4);
    chk("t5.armed", 32'(armed), 32'd0);

    // Reconfiguration flushes history; the same-cycle bit is dropped
    load("t6aload", 8'h0A, 4'd4, 1);
    feed("t6apre", 8'h05, 3);
    cur_pat = 8'h0A; cur_len = 4'd4; cur_ovl = 1;
    step("t6areload", 1, 1, 0, 0);
    pulses = 0;
    feed("t6aone", 8'h00, 1);
    chk("t6a.nomatch", 32'(pulses), 32'd0);
    feed("t6afresh", 8'h0A, 4);
    chk("t6a.match", 32'(pulses), 32'd1);

    // Disable with len 0
    load("t6bload", 8'h01, 4'd0, 1);
    chk("t6b.armed", 32'(armed), 32'd0);
    pulses = 0;
    feed("t6b", 8'hFF, 8);
    chk("t6b.pulses", 32'(pulses), 32'd0);

    // Over-long length clamps to MAX_LEN
    load("t6cload", 8'h3C, 4'd12, 0);
    pulses = 0;
    feed("t6c", 8'h3C, 8);
    chk("t6c.pulses", 32'(pulses), 32'd1);
    feed("t6cpart", 8'h0C, 4);

    // Random phase
    step("rclr", 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4 || n == 0) begin
        seq = 8'($urandom);
        load("rload", seq,
             ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 12)) : 4'($urandom_range(1, 3)),
             1'($urandom_range(0, 1)));
      end else begin
        step("rand", 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), r >= 97);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
